// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size codes, FSM state encoding and alignment rule shared by the memory access unit.
package mem_access_pkg;
  typedef enum logic [1:0] {SZ_WORD = 2'b00, SZ_HALF = 2'b01, SZ_BYTE = 2'b10, SZ_RSVD = 2'b11} size_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RESP} state_t;
  function automatic logic misaligned(size_t size, logic [1:0] lane);
    return size == SZ_RSVD || (size == SZ_HALF && lane[0]) || (size == SZ_WORD && lane != 2'b00);
  endfunction
endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: CPU request/response handshake plus the Memoria word bus.
interface mem_access_if #(parameter int ADDR_W = 32);
  logic req_valid, req_ready, req_write, req_unsigned;
  logic [1:0] req_size;
  logic [ADDR_W-1:0] req_addr, mem_addr;
  logic [31:0] req_wdata, resp_rdata, mem_wdata, mem_rdata;
  logic resp_valid, resp_err, mem_wr;
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wr, mem_wdata
  );
  modport slave (
    input req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane extraction/extension for loads and lane insertion for stores.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_t       size,
  input  logic        zext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    load_data = size == SZ_BYTE ? {{24{b[7] & ~zext}}, b}
              : size == SZ_HALF ? {{16{h[15] & ~zext}}, h} : word;
    store_data = size == SZ_WORD ? wdata : word;
    if (size == SZ_BYTE) store_data[{lane, 3'b000} +: 8] = wdata[7:0];
    else if (size == SZ_HALF) store_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer to a word-wide Memoria; sub-word stores use read-modify-write.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic reset,
  mem_access_if.slave bus
);
  state_t state, next;
  size_t size_in, size_q;
  logic [2:0] cnt;
  logic [1:0] lane_q;
  logic write_q, zext_q, err_q, err_in, last, ready, resp, wr;
  logic [31:0] wdata_q, word_q, load_data, store_data;
  logic [ADDR_W-1:0] addr_q;

  assign size_in = size_t'(bus.req_size);
  assign err_in = misaligned(size_in, bus.req_addr[1:0]);
  assign last = cnt == 3'(MEM_LAT);

  always_ff @(posedge clk)
    if (reset) state <= ST_IDLE;
    else state <= next;

  always_comb
    next = state == ST_IDLE ? (!bus.req_valid ? ST_IDLE : err_in ? ST_RESP
                               : (bus.req_write && size_in == SZ_WORD) ? ST_WR : ST_RD)
         : state == ST_RD ? (!last ? ST_RD : write_q ? ST_WR : ST_RESP)
         : state == ST_WR ? ST_RESP : ST_IDLE;

  always_comb begin
    ready = state == ST_IDLE;
    resp = state == ST_RESP;
    wr = state == ST_WR;
    bus.req_ready = ready;
    bus.resp_valid = resp;
    bus.resp_err = resp && err_q;
    bus.resp_rdata = (resp && !err_q && !write_q) ? load_data : '0;
    bus.mem_wr = wr;
    bus.mem_wdata = wr ? store_data : '0;
    bus.mem_addr = addr_q;
  end

  // RD spans MEM_LAT+1 cycles: address presentation plus MEM_LAT cycles of read latency
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      addr_q <= '0;
      size_q <= SZ_WORD;
      lane_q <= '0;
      write_q <= 1'b0;
      zext_q <= 1'b0;
      err_q <= 1'b0;
      wdata_q <= '0;
      word_q <= '0;
    end else begin
      cnt <= (state == ST_RD && !last) ? cnt + 3'd1 : '0;
      if (ready && bus.req_valid) begin
        size_q <= size_in;
        lane_q <= bus.req_addr[1:0];
        write_q <= bus.req_write;
        zext_q <= bus.req_unsigned;
        err_q <= err_in;
        wdata_q <= bus.req_wdata;
        if (!err_in) addr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
      end
      if (state == ST_RD && last) word_q <= bus.mem_rdata;
    end

  mem_lane_align u_align (
    .word(word_q),
    .lane(lane_q),
    .size(size_q),
    .zext(zext_q),
    .wdata(wdata_q),
    .load_data(load_data),
    .store_data(store_data)
  );
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Sequencer between the multicycle CPU datapath and the byte-addressed Memoria block. Executes word, halfword and byte loads and stores (lw/lh/lhu/lb/lbu/sw/sh/sb) with a valid/ready request and a one-cycle response pulse. Sub-word stores use read-modify-write on the aligned word. Misaligned or reserved-size requests return an error response for the control unit's exception path.

Parameters:
MEM_LAT, 1, cycles from mem_addr presentation to valid mem_rdata (1..7)
ADDR_W, 32, address width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (IDLE only)
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 word, 01 half, 10 byte, 11 reserved
req_unsigned  in  1  loads only: zero-extend instead of sign-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data; the low byte or half is used for sub-word stores
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  qualified by resp_valid: misaligned or reserved size
resp_rdata  out  32  qualified by resp_valid: extended load data; 0 for stores and errors
mem_addr  out  ADDR_W  word-aligned address to Memoria
mem_wr  out  1  Memoria write enable
mem_wdata  out  32  Memoria write data
mem_rdata  in  32  Memoria read data

Behaviour:
- One clock (clk). Reset is synchronous and active-high; all state updates occur on the rising edge of clk.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wr=0, mem_wdata=0, latency counter=0.
- Acceptance:
  - A request is accepted at edge T when req_valid && req_ready.
  - The unit registers addr, size, write, unsigned and wdata at T.
  - Input changes after T have no effect on the operation.
- Memory ordering: little-endian. Byte lane = addr[1:0]; half lane = addr[1]. mem_addr = {addr[ADDR_W-1:2], 2'b00}.
- Alignment check at acceptance:
  - Error if size=11, size=01 with addr[0]=1, or size=00 with addr[1:0]!=0.
  - On error: IDLE goes directly to RESP. resp_err=1 in cycle T+1. No memory access; mem_wr stays 0.
- States: IDLE, RD, WR, RESP.
  - IDLE: req_ready=1. On an accepted error go to RESP. On an accepted load or sub-word store go to RD. On an accepted sw go to WR.
  - RD: drive mem_addr with mem_wr=0 and count MEM_LAT cycles. In the last counted cycle, capture mem_rdata. A load then goes to RESP; a sub-word store goes to WR.
  - WR: mem_wr=1 for exactly one cycle. mem_wdata = req_wdata for sw, or the captured word with the target lane replaced for sh/sb. Next state is RESP.
  - RESP: resp_valid=1 for one cycle, then IDLE. req_ready is 0 in every state except IDLE.
- Response timing with MEM_LAT=1 (T = acceptance edge, resp_valid high in the cycle listed):
  - Error: T+1.
  - sw: mem_wr in T+1, resp_valid in T+2.
  - Load: resp_valid in T+3.
  - sh/sb: mem_wr in T+3, resp_valid in T+4.
  - Each additional MEM_LAT cycle delays every read path by one cycle.
- Load extension: the selected byte or half is sign-extended (req_unsigned=0) or zero-extended (1). Word loads ignore req_unsigned.
- mem_addr holds its value outside RD/WR; it does not return to 0.
- Back-to-back requests: the earliest possible next acceptance is the cycle after RESP. There are no overlapping operations.
- Reset mid-operation:
  - The state returns to IDLE at the next edge.
  - mem_wr=0 and resp_valid=0 from that edge onward.
  - The pending operation is dropped with no response.
  - A partially completed RMW leaves memory unmodified, because the write occurs only in WR.

Decomposition:
- Package mem_access_pkg holds:
  - size codes SZ_WORD, SZ_HALF, SZ_BYTE, SZ_RSVD;
  - state encoding ST_IDLE, ST_RD, ST_WR, ST_RESP.
- One combinational sub-module, mem_lane_align, handles lane extraction plus extension for loads and lane insertion for stores. It is shared by the load and RMW paths.

Test Plan:
- Memory[0x100]=0x8899AABB; lw 0x100 accepted at T -> resp_valid in T+3, resp_rdata=0x8899AABB, resp_err=0, mem_wr never asserted.
- Same word: lb 0x103 -> 0xFFFFFF88; lbu 0x103 -> 0x00000088; lh 0x102 -> 0xFFFF8899; lhu 0x100 -> 0x0000AABB.
- sb 0x101 with wdata 0x12345677 -> single mem_wr pulse in T+3 with mem_addr=0x100 and mem_wdata=0x889977BB; resp_valid in T+4; a follow-up lw returns 0x889977BB.
- sh 0x101, then lw 0x102, then size=11 -> each gives resp_err=1 in T+1 with resp_rdata=0, no mem_wr, and req_ready=1 at T+2.
- sw 0x104 with data 0xDEADBEEF while req_valid is held high with a second request queued -> mem_wr in T+1, resp in T+2, second request accepted at T+3 (not earlier).
- sb in progress with reset asserted in the RD cycle -> IDLE and req_ready=1 after the edge, no mem_wr, no resp_valid, memory word unchanged.
